// File: rtl/acc_pkg.sv
// Shared types for the accelerator offload path: controller FSM states and
// the request/response channel structs exchanged with the interconnect.
package acc_pkg;

  localparam int AccIdWidth   = 5;
  localparam int AccDataWidth = 32;
  localparam int AccNumIds    = 1 << AccIdWidth;

  typedef enum logic [1:0] {ACTIVE, DRAIN, QUIESCED} acc_ctrl_state_e;

  typedef struct packed {
    logic [AccIdWidth-1:0]   id;
    logic [AccDataWidth-1:0] data;
  } acc_q_t;

  typedef struct packed {
    logic [AccIdWidth-1:0]   id;
    logic [AccDataWidth-1:0] data;
  } acc_p_t;

  typedef struct packed {
    acc_q_t q;
    logic   q_valid;
    logic   p_ready;
  } acc_req_t;

  typedef struct packed {
    acc_p_t p;
    logic   q_ready;
    logic   p_valid;
  } acc_rsp_t;

endpackage

// File: rtl/acc_id_scoreboard.sv
// Busy bitmap with one bit per offload id; set on issue, cleared on retire.
// clr_hit reports whether the retiring id is currently marked busy.
module acc_id_scoreboard
  import acc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  set_valid,
  input  logic [AccIdWidth-1:0] set_id,
  input  logic                  clr_valid,
  input  logic [AccIdWidth-1:0] clr_id,
  output logic [AccNumIds-1:0]  busy,
  output logic                  clr_hit
);

  for (genvar gi = 0; gi < AccNumIds; gi++) begin : g_bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        busy[gi] <= 1'b0;
      end else if (set_valid && set_id == AccIdWidth'(gi)) begin
        busy[gi] <= 1'b1;
      end else if (clr_valid && clr_id == AccIdWidth'(gi)) begin
        busy[gi] <= 1'b0;
      end
    end
  end

  assign clr_hit = busy[clr_id];

endmodule

// File: rtl/acc_offload_ctrl.sv
// Per-requester offload controller: caps in-flight offloads, blocks duplicate
// ids, retires ids on responses and offers a flush/quiesce handshake.
module acc_offload_ctrl
  import acc_pkg::*;
#(
  parameter int  MaxOutstanding = 4,
  parameter type req_t          = acc_req_t,
  parameter type rsp_t          = acc_rsp_t,
  localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                idle_o,
  output logic                err_o,
  output logic [CntWidth-1:0] outstanding_o,
  input  req_t                slv_req_i,
  output rsp_t                slv_rsp_o,
  output req_t                mst_req_o,
  input  rsp_t                mst_rsp_i
);

  localparam logic [CntWidth-1:0] MaxCount = CntWidth'(MaxOutstanding);

  acc_ctrl_state_e       state_q, state_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  lock_q, lock_d;
  logic                  err_q;
  logic [AccNumIds-1:0]  busy;
  logic                  clr_hit;
  logic                  allow, issue, retire;

  // Gating with rst_ni keeps every handshake output low while reset is held.
  assign allow = rst_ni & (lock_q |
                 (state_q == ACTIVE && count_q < MaxCount && !busy[slv_req_i.q.id]));

  always_comb begin
    mst_req_o         = slv_req_i;
    mst_req_o.q_valid = slv_req_i.q_valid & allow;
    mst_req_o.p_ready = slv_req_i.p_ready & rst_ni;
    slv_rsp_o         = mst_rsp_i;
    slv_rsp_o.q_ready = mst_rsp_i.q_ready & allow;
    slv_rsp_o.p_valid = mst_rsp_i.p_valid & rst_ni;
  end

  assign issue  = slv_req_i.q_valid & allow & mst_rsp_i.q_ready;
  assign retire = mst_rsp_i.p_valid & slv_req_i.p_ready;

  acc_id_scoreboard u_scoreboard (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .set_valid(issue),
    .set_id   (slv_req_i.q.id),
    .clr_valid(retire),
    .clr_id   (mst_rsp_i.p.id),
    .busy     (busy),
    .clr_hit  (clr_hit)
  );

  always_comb begin
    count_d = count_q;
    case ({issue, retire & clr_hit})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // An offer that was not accepted stays allowed until it is.
  always_comb begin
    lock_d = lock_q;
    if (slv_req_i.q_valid && allow && !mst_rsp_i.q_ready) begin
      lock_d = 1'b1;
    end else if (issue) begin
      lock_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE:   if (flush_i && !lock_q) state_d = DRAIN;
      DRAIN: begin
        if (!flush_i)            state_d = ACTIVE;
        else if (count_q == '0)  state_d = QUIESCED;
      end
      QUIESCED: if (!flush_i) state_d = ACTIVE;
      default:  state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACTIVE;
      count_q <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lock_q  <= lock_d;
      err_q   <= retire & ~clr_hit;
    end
  end

  assign idle_o        = (state_q == QUIESCED);
  assign err_o         = err_q;
  assign outstanding_o = count_q;

endmodule

// File: tb/tb_acc_offload_ctrl.sv
// Randomized and directed bench for acc_offload_ctrl, checked every cycle
// against an id-set reference model plus literal expectations.
module tb_acc_offload_ctrl;
  import acc_pkg::*;

  localparam int Max = 4;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  logic     flush = 1'b0;
  logic     idle, err;
  logic [2:0] outstanding;
  acc_req_t slv_req, mst_req;
  acc_rsp_t slv_rsp, mst_rsp;

  always #5 clk = ~clk;

  acc_offload_ctrl #(.MaxOutstanding(Max)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .idle_o       (idle),
    .err_o        (err),
    .outstanding_o(outstanding),
    .slv_req_i    (slv_req),
    .slv_rsp_o    (slv_rsp),
    .mst_req_o    (mst_req),
    .mst_rsp_i    (mst_rsp)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: set of in-flight ids, mode, pending-offer flag, error pulse.
  bit infl[32];
  int m_mode;      // 0 running, 1 draining, 2 quiesced
  bit m_pending;
  bit m_err;
  bit hold;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(infl[i]);
    return c;
  endfunction

  always @(negedge clk) begin : cmp
    bit ok, exp_qv, exp_qr, acc, ret, hit;
    int cnt;
    if (!rst_n) begin
      chk("rst_mst_q_valid", mst_req.q_valid, 0);
      chk("rst_slv_q_ready", slv_rsp.q_ready, 0);
      chk("rst_slv_p_valid", slv_rsp.p_valid, 0);
      chk("rst_mst_p_ready", mst_req.p_ready, 0);
      chk("rst_idle", idle, 0);
      chk("rst_err", err, 0);
      chk("rst_outstanding", outstanding, 0);
      for (int i = 0; i < 32; i++) infl[i] = 0;
      m_mode = 0; m_pending = 0; m_err = 0; hold = 0;
    end else begin
      cnt    = m_count();
      ok     = m_pending || (m_mode == 0 && cnt < Max && !infl[slv_req.q.id]);
      exp_qv = slv_req.q_valid && ok;
      exp_qr = mst_rsp.q_ready && ok;
      chk("mst_q", mst_req.q, slv_req.q);
      chk("mst_q_valid", mst_req.q_valid, exp_qv);
      chk("slv_q_ready", slv_rsp.q_ready, exp_qr);
      chk("slv_p", slv_rsp.p, mst_rsp.p);
      chk("slv_p_valid", slv_rsp.p_valid, mst_rsp.p_valid);
      chk("mst_p_ready", mst_req.p_ready, slv_req.p_ready);
      chk("idle", idle, m_mode == 2);
      chk("err", err, m_err);
      chk("outstanding", outstanding, cnt);
      acc = exp_qv && mst_rsp.q_ready;
      ret = mst_rsp.p_valid && slv_req.p_ready;
      hit = infl[mst_rsp.p.id];
      if (m_mode == 0 && flush && !m_pending) m_mode = 1;
      else if (m_mode == 1 && !flush) m_mode = 0;
      else if (m_mode == 1 && cnt == 0) m_mode = 2;
      else if (m_mode == 2 && !flush) m_mode = 0;
      m_err = ret && !hit;
      if (ret && hit) infl[mst_rsp.p.id] = 0;
      if (acc) infl[slv_req.q.id] = 1;
      if (exp_qv && !mst_rsp.q_ready) m_pending = 1;
      else if (acc) m_pending = 0;
      hold = exp_qv && !mst_rsp.q_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int id, input bit qr);
    slv_req.q_valid = 1'b1;
    slv_req.q.id    = 5'(id);
    slv_req.q.data  = 32'($urandom);
    mst_rsp.q_ready = qr;
  endtask

  task automatic respond(input int id);
    mst_rsp.p_valid = 1'b1;
    mst_rsp.p.id    = 5'(id);
    mst_rsp.p.data  = 32'($urandom);
    slv_req.p_ready = 1'b1;
  endtask

  task automatic quiet();
    slv_req = '0;
    mst_rsp = '0;
  endtask

  initial begin
    int ids[$];
    quiet();
    repeat (2) @(posedge clk);
    #1;
    slv_req.q_valid = 1; mst_rsp.q_ready = 1; mst_rsp.p_valid = 1; slv_req.p_ready = 1;
    #2;
    chk("reset_q_valid_low", mst_req.q_valid, 0);
    chk("reset_q_ready_low", slv_rsp.q_ready, 0);
    step(); rst_n = 1; quiet();

    // Fill to the limit, then a fifth id is refused.
    for (int i = 0; i < 4; i++) begin
      step(); offer(i, 1); #2; chk("fill_issue", mst_req.q_valid, 1);
    end
    step(); offer(4, 1); #2;
    chk("full_outstanding", outstanding, 4);
    chk("full_q_valid", mst_req.q_valid, 0);
    chk("full_q_ready", slv_rsp.q_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step(); quiet(); respond(i);
    end
    step(); quiet(); #2; chk("drained_outstanding", outstanding, 0);

    // Duplicate id is held off until its response retires.
    step(); offer(7, 1); #2; chk("dup_first", mst_req.q_valid, 1);
    step(); #2; chk("dup_blocked", mst_req.q_valid, 0);
    step(); respond(7); #2; chk("dup_blocked_on_rsp", mst_req.q_valid, 0);
    step(); mst_rsp.p_valid = 0; #2; chk("dup_reissue", mst_req.q_valid, 1);
    step(); quiet(); respond(7);
    step(); quiet(); #2; chk("dup_outstanding", outstanding, 0);

    // Flush while an offer is stalled: offer held, then drain to idle.
    step(); offer(2, 0); #2; chk("lock_offer", mst_req.q_valid, 1);
    step(); flush = 1; #2; chk("lock_hold_flush", mst_req.q_valid, 1);
    step(); #2; chk("lock_hold2", mst_req.q_valid, 1); chk("lock_not_idle", idle, 0);
    step(); mst_rsp.q_ready = 1; #2; chk("lock_accept", mst_req.q_valid, 1);
    step(); quiet(); #2; chk("flush_outstanding", outstanding, 1);
    step(); respond(2);
    step(); quiet(); #2; chk("flush_cnt0", outstanding, 0); chk("flush_idle_early", idle, 0);
    step(); offer(3, 1); #2; chk("flush_idle", idle, 1); chk("quiesced_block", mst_req.q_valid, 0);
    step(); quiet(); flush = 0;
    step(); #2; chk("unflush_idle", idle, 0);

    // Issue and retire together keeps the count.
    step(); offer(1, 1);
    step(); offer(3, 1);
    step(); offer(5, 1); respond(1); #2;
    chk("swap_issue", mst_req.q_valid, 1); chk("swap_before", outstanding, 2);
    step(); quiet(); offer(5, 0); #2;
    chk("swap_after", outstanding, 2); chk("swap_busy5", mst_req.q_valid, 0);
    step(); offer(1, 1); #2; chk("swap_free1", mst_req.q_valid, 1);
    step(); quiet(); #2; chk("swap_three", outstanding, 3);
    ids = '{1, 3, 5};
    foreach (ids[k]) begin
      step(); quiet(); respond(ids[k]);
    end
    step(); quiet(); #2; chk("swap_drained", outstanding, 0);

    // Stray response id.
    step(); respond(9); mst_rsp.p.data = 32'h1234_5678; #2;
    chk("stray_fwd_valid", slv_rsp.p_valid, 1);
    chk("stray_fwd_id", slv_rsp.p.id, 9);
    chk("stray_fwd_data", slv_rsp.p.data, 32'h1234_5678);
    step(); quiet(); #2; chk("stray_err", err, 1); chk("stray_outstanding", outstanding, 0);
    step(); #2; chk("stray_err_once", err, 0);

    // Reset with three in flight.
    for (int i = 0; i < 3; i++) begin
      step(); offer(i, 1);
    end
    step(); offer(3, 1); #2; chk("pre_rst_outstanding", outstanding, 3);
    rst_n = 0; #1;
    chk("async_q_valid", mst_req.q_valid, 0);
    chk("async_q_ready", slv_rsp.q_ready, 0);
    chk("async_outstanding", outstanding, 0);
    step(); rst_n = 1; quiet();
    step(); respond(1); #2; chk("post_rst_outstanding", outstanding, 0); chk("post_rst_idle", idle, 0);
    step(); quiet(); #2; chk("post_rst_err", err, 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step();
      if (!hold) begin
        slv_req.q_valid = 1'($urandom_range(0, 1));
        slv_req.q.id    = 5'($urandom_range(0, 7));
        slv_req.q.data  = 32'($urandom);
      end
      mst_rsp.q_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) flush = ~flush;
      ids.delete();
      for (int i = 0; i < 32; i++) if (infl[i]) ids.push_back(i);
      mst_rsp.p_valid = ($urandom_range(0, 2) == 0);
      if (ids.size() > 0 && $urandom_range(0, 7) != 0)
        mst_rsp.p.id = 5'(ids[$urandom_range(0, ids.size() - 1)]);
      else
        mst_rsp.p.id = 5'($urandom_range(0, 31));
      mst_rsp.p.data  = 32'($urandom);
      slv_req.p_ready = ($urandom_range(0, 3) != 0);
    end
    step(); quiet(); flush = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
